// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg: default sizing constants and segment-width helper shared by pipe_rca.
package pipe_rca_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // Bits added per pipeline stage.
    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_rca_fa_cell.sv
// fa_cell: 1-bit full adder.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_rca.sv
// pipe_rca: pipelined ripple-carry adder with valid/ready handshake on both sides.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid, in_ready   : operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, ci             : unsigned operands and carry in
//   out_valid, out_ready : result handshake
//   s, co                : sum and carry out, {co,s} = a+b+ci
//   ovf                  : signed overflow, present only when PIPE_RCA_OVF_EN is defined
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef PIPE_RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_rca: WIDTH must be >= 1 and an exact multiple of STAGES >= 1");
    end

    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage k registers the sum of bits [0 +: (k+1)*SEG] plus the operand bits
    // not yet consumed, so upper slices arrive k cycles late and lower sum
    // slices ride along until the whole result emerges together.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SEG;
        localparam int RW = WIDTH - LO - SEG;
        logic [WIDTH-LO-1:0] ah_in, bh_in;
        logic [SEG-1:0]      ss;
        logic [SEG:0]        cc;
        logic [LO+SEG-1:0]   sum_d, sum_q;
        logic                v_d, v_q, c_q;
        for (genvar i = 0; i < SEG; i++) begin : g_fa
            fa_cell u_fa (
                .a (ah_in[i]),
                .b (bh_in[i]),
                .ci(cc[i]),
                .s (ss[i]),
                .co(cc[i+1])
            );
        end
        if (k == 0) begin : g_in
            assign ah_in = a;
            assign bh_in = b;
            assign cc[0] = ci;
            assign v_d   = in_valid;
            assign sum_d = ss;
        end else begin : g_in
            assign ah_in = g_st[k-1].g_rest.ah_q;
            assign bh_in = g_st[k-1].g_rest.bh_q;
            assign cc[0] = g_st[k-1].c_q;
            assign v_d   = g_st[k-1].v_q;
            assign sum_d = {ss, g_st[k-1].sum_q};
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_d;
                c_q   <= cc[SEG];
                sum_q <= sum_d;
            end
        end
        if (RW > 0) begin : g_rest
            logic [RW-1:0] ah_q, bh_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ah_q <= '0;
                    bh_q <= '0;
                end else if (adv) begin
                    ah_q <= ah_in[WIDTH-LO-1:SEG];
                    bh_q <= bh_in[WIDTH-LO-1:SEG];
                end
            end
        end
`ifdef PIPE_RCA_OVF_EN
        // cc[SEG-1] is the carry into bit WIDTH-1 when this is the last stage.
        if (k == STAGES - 1) begin : g_ovf
            logic o_q;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    o_q <= 1'b0;
                else if (adv)
                    o_q <= cc[SEG-1] ^ cc[SEG];
            end
        end
`endif
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign s         = g_st[STAGES-1].sum_q;
    assign co        = g_st[STAGES-1].c_q;
`ifdef PIPE_RCA_OVF_EN
    assign ovf       = g_st[STAGES-1].g_ovf.o_q;
`endif

endmodule

// File: tb/tb_pipe_rca.sv
// tb_pipe_rca: directed self-checking bench for pipe_rca (8/2 main instance, 4/4 and 4/1 exhaustive).
module tb_pipe_rca;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, ci, co, ovf;
    logic [7:0] a, b, s;

    logic [3:0] a4, b4, s4, s1;
    logic       ci4, iv4, ir4, ov4, or4, co4, ovf4;
    logic       iv1, ir1, ov1, or1, co1, ovf1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pipe_rca #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co)
`ifdef PIPE_RCA_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipe_rca #(.WIDTH(4), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .ci(ci4), .out_valid(ov4), .out_ready(or4),
        .s(s4), .co(co4)
`ifdef PIPE_RCA_OVF_EN
        , .ovf(ovf4)
`endif
    );

    pipe_rca #(.WIDTH(4), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a4), .b(b4), .ci(ci4), .out_valid(ov1), .out_ready(or1),
        .s(s1), .co(co1)
`ifdef PIPE_RCA_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        ci       = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 8'hA5, 8'h5A, 1'b1);
        iv4 = 1'b1; iv1 = 1'b1; or4 = 1'b0; or1 = 1'b0;
        a4 = 4'h3; b4 = 4'h4; ci4 = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if ({co, s} !== 9'h000) begin errors++; $display("FAIL reset_sum: got %h want 000", {co, s}); end
        vectors++;
        if ({ov4, ov1} !== 2'b00) begin errors++; $display("FAIL reset_small_valid: got %b want 00", {ov4, ov1}); end
`ifdef PIPE_RCA_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        iv4 = 1'b0; iv1 = 1'b0;
    endtask

    // Released from reset together with the first operands: they must be taken on that edge.
    task automatic test_carry_wrap();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_in_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_early_valid: got %b want 0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
        vectors++;
        if ({co, s} !== 9'h100) begin errors++; $display("FAIL wrap_sum: got %h want 100", {co, s}); end
`ifdef PIPE_RCA_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", ovf); end
`endif
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_bubble: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [4] = '{8'h10, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] tb [4] = '{8'h20, 8'h01, 8'h80, 8'hFF};
        logic       tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] ts [4] = '{9'h030, 9'h080, 9'h100, 9'h1FF};
        logic       to [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, ta[i], tb[i], tc[i]);
            else drive(1'b0, 8'h00, 8'h00, 1'b0);
            tick();
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i - 1, out_valid); end
                vectors++;
                if ({co, s} !== ts[i-1]) begin errors++; $display("FAIL b2b_sum[%0d]: got %h want %h", i - 1, {co, s}, ts[i-1]); end
`ifdef PIPE_RCA_OVF_EN
                vectors++;
                if (ovf !== to[i-1]) begin errors++; $display("FAIL b2b_ovf[%0d]: got %b want %b", i - 1, ovf, to[i-1]); end
`endif
            end
        end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 1'b0);
        tick();
        drive(1'b1, 8'h40, 8'h40, 1'b0);
        tick();
        drive(1'b1, 8'h05, 8'h06, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
            vectors++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
            vectors++;
            if ({co, s} !== 9'h003) begin errors++; $display("FAIL stall_sum[%0d]: got %h want 003", i, {co, s}); end
`ifdef PIPE_RCA_OVF_EN
            vectors++;
            if (ovf !== 1'b0) begin errors++; $display("FAIL stall_ovf[%0d]: got %b want 0", i, ovf); end
`endif
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || {co, s} !== 9'h080) begin errors++; $display("FAIL release_first: got v=%b %h want v=1 080", out_valid, {co, s}); end
`ifdef PIPE_RCA_OVF_EN
        vectors++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL release_ovf: got %b want 1", ovf); end
`endif
        tick();
        vectors++;
        if (out_valid !== 1'b1 || {co, s} !== 9'h00C) begin errors++; $display("FAIL release_second: got v=%b %h want v=1 00c", out_valid, {co, s}); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        tick();
        drive(1'b1, 8'h33, 8'h44, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        vectors++;
        if ({co, s} !== 9'h000) begin errors++; $display("FAIL midrst_sum: got %h want 000", {co, s}); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d]: got %b want 0 (s=%h)", i, out_valid, s); end
        end
    endtask

    // All (a,b,ci) through one of the 4-bit instances with random downstream backpressure.
    task automatic test_exhaustive(input logic sel);
        logic [4:0] q [$];
        logic [4:0] exp_v;
        logic       ir, ov;
        logic [4:0] got;
        int         idx = 0;
        int         cyc = 0;
        while (idx < 512 || q.size() != 0) begin
            if (cyc++ > 4000) begin
                errors++;
                vectors++;
                $display("FAIL exh%0d_timeout: got %0d issued %0d pending want 512 issued 0 pending", sel, idx, q.size());
                break;
            end
            a4  = 4'(idx);
            b4  = 4'(idx >> 4);
            ci4 = 1'(idx >> 8);
            if (sel) begin
                iv1 = (idx < 512);
                or1 = 1'($urandom_range(0, 1));
            end else begin
                iv4 = (idx < 512);
                or4 = 1'($urandom_range(0, 1));
            end
            #1;
            ir  = sel ? ir1 : ir4;
            ov  = sel ? ov1 : ov4;
            got = sel ? {co1, s1} : {co4, s4};
            if (ov && q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL exh%0d_spurious: got valid %h want no result", sel, got);
            end else if (ov && (sel ? or1 : or4)) begin
                exp_v = q.pop_front();
                vectors++;
                if (got !== exp_v) begin errors++; $display("FAIL exh%0d_sum: got %h want %h", sel, got, exp_v); end
            end
            if ((sel ? iv1 : iv4) && ir) begin
                q.push_back(5'(a4) + 5'(b4) + 5'(ci4));
                idx++;
            end
            tick();
        end
        iv4 = 1'b0; iv1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_exhaustive(1'b0);
        test_exhaustive(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
